mult_share_arb: RTL and testbench

Round-robin arbiter and sequencer that shares one pipelined dedicated multiplier (clock-enabled, fixed latency) between several requesters in the picoMIPS datapath. It accepts operand pairs over a valid/ready handshake, drives the multiplier's operand and clock-enable inputs, and tracks each operation through the pipeline. Each product is returned to the requester that issued it. It sits between the multiplier instance and its clients: the ALU multiply path and the multiplier-backed register writes.

---
 rtl/mult_share_arb_if.sv | 28 ++
 rtl/mult_share_arb.sv | 130 +++++++++++++
 tb/tb_mult_share_arb.sv | 401 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mult_share_arb_if.sv
// Requester, multiplier and response signals of the shared-multiplier arbiter.
// The slave side is the arbiter; the master side is the surrounding datapath.
interface mult_share_arb_if #(
    parameter int WIDTH = 8,
    parameter int NREQ  = 2
);
    logic [NREQ-1:0]       req_valid;
    logic [NREQ*WIDTH-1:0] req_a;
    logic [NREQ*WIDTH-1:0] req_b;
    logic [NREQ-1:0]       req_ready;
    logic [WIDTH-1:0]      mult_a;
    logic [WIDTH-1:0]      mult_b;
    logic                  mult_en;
    logic [2*WIDTH-1:0]    mult_result;
    logic [NREQ-1:0]       rsp_valid;
    logic [2*WIDTH-1:0]    rsp_data;
    logic                  busy;

    modport slave (
        input  req_valid, req_a, req_b, mult_result,
        output req_ready, mult_a, mult_b, mult_en, rsp_valid, rsp_data, busy
    );

    modport master (
        output req_valid, req_a, req_b, mult_result,
        input  req_ready, mult_a, mult_b, mult_en, rsp_valid, rsp_data, busy
    );
endinterface

// File: rtl/mult_share_arb.sv
// Round-robin sharing of one clock-enabled, fixed-latency pipelined multiplier.
// A tag pipeline advancing with the multiplier routes each product back to its issuer.
module mult_share_arb #(
    parameter int WIDTH   = 8,
    parameter int NREQ    = 2,
    parameter int LATENCY = 1
) (
    input  logic            clk,
    input  logic            n_reset,
    mult_share_arb_if.slave bus
);

    localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_t;

    function automatic logic [NREQ-1:0] onehot(input logic [IDW-1:0] id);
        onehot = {{(NREQ-1){1'b0}}, 1'b1} << id;
    endfunction

    state_t                 state_r;
    state_t                 state_next_s;
    logic [IDW-1:0]         ptr_r;
    logic [IDW-1:0]         grant_id_s;
    logic [IDW-1:0]         idx_s;
    logic                   hit_s;
    logic [NREQ-1:0]        grant_s;
    logic                   issue_s;
    logic                   busy_s;
    logic                   mult_en_s;
    logic [WIDTH-1:0]       mult_a_s;
    logic [WIDTH-1:0]       mult_b_s;
    logic [LATENCY-1:0]     tag_valid_r;
    logic [LATENCY-1:0]     tag_valid_next_s;
    logic [LATENCY*IDW-1:0] tag_id_r;
    logic [LATENCY*IDW-1:0] tag_id_next_s;
    logic                   mid_valid_s;

    // Stage 0 sits in the low slot; everything moves up one slot per enabled edge
    generate
        if (LATENCY > 1) begin : g_deep
            assign tag_valid_next_s = {tag_valid_r[LATENCY-2:0], issue_s};
            assign tag_id_next_s    = {tag_id_r[(LATENCY-1)*IDW-1:0], grant_id_s};
            assign mid_valid_s      = |tag_valid_r[LATENCY-2:0];
        end else begin : g_single
            assign tag_valid_next_s = issue_s;
            assign tag_id_next_s    = grant_id_s;
            assign mid_valid_s      = 1'b0;
        end
    endgenerate

    // Round-robin search starting one past the last granted requester
    always_comb begin
        grant_s    = '0;
        grant_id_s = '0;
        idx_s      = '0;
        hit_s      = 1'b0;
        for (int k = 1; k <= NREQ; k++) begin
            idx_s      = IDW'((int'(ptr_r) + k) % NREQ);
            hit_s      = n_reset & ~(|grant_s) & bus.req_valid[idx_s];
            grant_s    = grant_s | (onehot(idx_s) & {NREQ{hit_s}});
            grant_id_s = hit_s ? idx_s : grant_id_s;
        end
    end

    // Operand mux: AND-OR of the one-hot grant, zero when nobody is granted
    always_comb begin
        mult_a_s = '0;
        mult_b_s = '0;
        for (int i = 0; i < NREQ; i++) begin
            mult_a_s = mult_a_s | (bus.req_a[i*WIDTH +: WIDTH] & {WIDTH{grant_s[i]}});
            mult_b_s = mult_b_s | (bus.req_b[i*WIDTH +: WIDTH] & {WIDTH{grant_s[i]}});
        end
    end

    assign issue_s   = |grant_s;
    assign busy_s    = (state_r == ACTIVE);
    assign mult_en_s = n_reset & (issue_s | busy_s);

    // Next state: stay active while anything will still be in the tag pipeline
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE:    state_next_s = issue_s ? ACTIVE : IDLE;
            ACTIVE:  state_next_s = (issue_s || mid_valid_s) ? ACTIVE : IDLE;
            default: state_next_s = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Last-granted pointer; the reset value makes requester 0 win first
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            ptr_r <= IDW'(NREQ - 1);
        end else if (issue_s) begin
            ptr_r <= grant_id_s;
        end
    end

    // Tag pipeline advances only with the multiplier clock enable
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            tag_valid_r <= '0;
            tag_id_r    <= '0;
        end else if (mult_en_s) begin
            tag_valid_r <= tag_valid_next_s;
            tag_id_r    <= tag_id_next_s;
        end
    end

    assign bus.req_ready = grant_s;
    assign bus.mult_a    = mult_a_s;
    assign bus.mult_b    = mult_b_s;
    assign bus.mult_en   = mult_en_s;
    assign bus.rsp_valid = tag_valid_r[LATENCY-1] ? onehot(tag_id_r[LATENCY*IDW-1 -: IDW]) : '0;
    assign bus.rsp_data  = bus.mult_result;
    assign bus.busy      = busy_s;

endmodule

// File: tb/tb_mult_share_arb.sv
// Bench for mult_share_arb: one instance with LATENCY=1 and one with LATENCY=3, each
// driving a behavioural clock-enabled multiplier, checked against an issue-time queue model.
module tb_mult_share_arb;

    typedef struct {
        int          d;
        int          due;
        int          id;
        logic [15:0] prod;
    } pend_t;

    logic        clk;
    logic [1:0]  rstn;
    logic [1:0]  rv [2];
    logic [15:0] ra [2];
    logic [15:0] rb [2];
    logic [1:0]  o_ready [2];
    logic [7:0]  o_ma [2];
    logic [7:0]  o_mb [2];
    logic        o_en [2];
    logic [1:0]  o_rv [2];
    logic [15:0] o_rd [2];
    logic        o_busy [2];
    logic [15:0] m1_q;
    logic [15:0] m3_q [3];

    pend_t       pend [$];
    int          ptr [2];
    int          exp_gid [2];
    logic [37:0] exp_vec [2];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;

    mult_share_arb_if #(.WIDTH(8), .NREQ(2)) bus0 ();
    mult_share_arb_if #(.WIDTH(8), .NREQ(2)) bus1 ();

    mult_share_arb #(.WIDTH(8), .NREQ(2), .LATENCY(1)) dut0 (
        .clk(clk), .n_reset(rstn[0]), .bus(bus0.slave));
    mult_share_arb #(.WIDTH(8), .NREQ(2), .LATENCY(3)) dut1 (
        .clk(clk), .n_reset(rstn[1]), .bus(bus1.slave));

    assign bus0.req_valid   = rv[0];
    assign bus0.req_a       = ra[0];
    assign bus0.req_b       = rb[0];
    assign bus0.mult_result = m1_q;
    assign bus1.req_valid   = rv[1];
    assign bus1.req_a       = ra[1];
    assign bus1.req_b       = rb[1];
    assign bus1.mult_result = m3_q[2];

    assign o_ready[0] = bus0.req_ready;
    assign o_ma[0]    = bus0.mult_a;
    assign o_mb[0]    = bus0.mult_b;
    assign o_en[0]    = bus0.mult_en;
    assign o_rv[0]    = bus0.rsp_valid;
    assign o_rd[0]    = bus0.rsp_data;
    assign o_busy[0]  = bus0.busy;
    assign o_ready[1] = bus1.req_ready;
    assign o_ma[1]    = bus1.mult_a;
    assign o_mb[1]    = bus1.mult_b;
    assign o_en[1]    = bus1.mult_en;
    assign o_rv[1]    = bus1.rsp_valid;
    assign o_rd[1]    = bus1.rsp_data;
    assign o_busy[1]  = bus1.busy;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Stand-in multipliers: clock-enabled pipelines of depth 1 and 3
    always @(posedge clk) begin
        if (o_en[0]) m1_q <= {8'd0, o_ma[0]} * {8'd0, o_mb[0]};
    end

    always @(posedge clk) begin
        if (o_en[1]) begin
            m3_q[0] <= {8'd0, o_ma[1]} * {8'd0, o_mb[1]};
            m3_q[1] <= m3_q[0];
            m3_q[2] <= m3_q[1];
        end
    end

    function automatic int lat(input int d);
        return (d == 0) ? 1 : 3;
    endfunction

    function automatic logic [37:0] obs_vec(input int d);
        return {o_ready[d], o_en[d], o_busy[d], o_rv[d], o_ma[d], o_mb[d],
                (o_rv[d] != 2'b00) ? o_rd[d] : 16'h0000};
    endfunction

    // Expected outputs of cycle cyc from the round-robin rule and the issue-time queue
    task automatic model_eval(input int d);
        logic [1:0]  rdy;
        logic [1:0]  rvv;
        logic        en;
        logic        bsy;
        logic [7:0]  ma;
        logic [7:0]  mb;
        logic [15:0] rd;
        int          gid;
        int          i;
        pend_t       keep [$];
        rdy = 2'b00; rvv = 2'b00; en = 1'b0; bsy = 1'b0;
        ma = 8'd0; mb = 8'd0; rd = 16'd0; gid = -1;
        if (rstn[d] !== 1'b1) begin
            ptr[d] = 1;
            foreach (pend[j]) if (pend[j].d != d) keep.push_back(pend[j]);
            pend = keep;
        end else begin
            for (int k = 1; k <= 2; k++) begin
                i = (ptr[d] + k) % 2;
                if (gid < 0 && rv[d][i]) gid = i;
            end
            if (gid >= 0) begin
                rdy[gid] = 1'b1;
                ma = ra[d][gid*8 +: 8];
                mb = rb[d][gid*8 +: 8];
            end
            foreach (pend[j]) begin
                if (pend[j].d == d && pend[j].due >= cyc) bsy = 1'b1;
                if (pend[j].d == d && pend[j].due == cyc) begin
                    rvv[pend[j].id] = 1'b1;
                    rd = pend[j].prod;
                end
            end
            en = (gid >= 0) || bsy;
        end
        exp_vec[d] = {rdy, en, bsy, rvv, ma, mb, rd};
        exp_gid[d] = gid;
    endtask

    task automatic model_commit(input int d);
        pend_t e;
        pend_t keep [$];
        if (exp_gid[d] >= 0) begin
            ptr[d] = exp_gid[d];
            e.d    = d;
            e.due  = cyc + lat(d);
            e.id   = exp_gid[d];
            e.prod = {8'd0, ra[d][exp_gid[d]*8 +: 8]} * {8'd0, rb[d][exp_gid[d]*8 +: 8]};
            pend.push_back(e);
        end
        foreach (pend[j]) if (!(pend[j].d == d && pend[j].due <= cyc)) keep.push_back(pend[j]);
        pend = keep;
    endtask

    task automatic to_next();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rstn = 2'b00;
        for (int k = 0; k < 6; k++) begin
            to_next();
            if (k == 3) rstn = 2'b11;
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                model_eval(d);
                checks++;
                if (obs_vec(d) !== 38'd0) begin
                    errors++;
                    $display("FAIL reset_idle dut%0d cyc=%0d got=%h exp=%h", d, cyc, obs_vec(d), 38'd0);
                end
                model_commit(d);
            end
        end
    endtask

    task automatic test_contention();
        logic [17:0] er;
        for (int k = 0; k < 7; k++) begin
            to_next();
            rv[0] = (k < 4) ? 2'b11 : 2'b00;
            ra[0] = {8'd4, 8'd2};
            rb[0] = {8'd9, 8'd7};
            @(negedge clk);
            model_eval(0);
            checks++;
            if (obs_vec(0) !== exp_vec[0]) begin
                errors++;
                $display("FAIL contention_model cyc=%0d got=%h exp=%h", cyc, obs_vec(0), exp_vec[0]);
            end
            if (k < 4) begin
                checks++;
                if (o_ready[0] !== ((k % 2 == 0) ? 2'b01 : 2'b10)) begin
                    errors++;
                    $display("FAIL contention_grant k=%0d got=%b exp=%b", k, o_ready[0],
                             (k % 2 == 0) ? 2'b01 : 2'b10);
                end
            end
            if (k >= 1 && k <= 4) begin
                er = ((k - 1) % 2 == 0) ? {2'b01, 16'd14} : {2'b10, 16'd36};
                checks++;
                if ({o_rv[0], o_rd[0]} !== er) begin
                    errors++;
                    $display("FAIL contention_rsp k=%0d got=%h exp=%h", k, {o_rv[0], o_rd[0]}, er);
                end
            end
            model_commit(0);
        end
    endtask

    task automatic test_single();
        for (int k = 0; k < 3; k++) begin
            to_next();
            rv[0] = (k == 0) ? 2'b01 : 2'b00;
            ra[0] = {8'd0, 8'd3};
            rb[0] = {8'd0, 8'd5};
            @(negedge clk);
            model_eval(0);
            checks++;
            if (obs_vec(0) !== exp_vec[0]) begin
                errors++;
                $display("FAIL single_model cyc=%0d got=%h exp=%h", cyc, obs_vec(0), exp_vec[0]);
            end
            if (k == 0) begin
                checks++;
                if (o_ready[0] !== 2'b01) begin
                    errors++;
                    $display("FAIL single_grant got=%b exp=01", o_ready[0]);
                end
            end else if (k == 1) begin
                checks++;
                if ({o_rv[0], o_rd[0]} !== {2'b01, 16'd15}) begin
                    errors++;
                    $display("FAIL single_rsp got=%b/%0d exp=01/15", o_rv[0], o_rd[0]);
                end
            end else begin
                checks++;
                if (o_busy[0] !== 1'b0) begin
                    errors++;
                    $display("FAIL single_busy got=%b exp=0", o_busy[0]);
                end
            end
            model_commit(0);
        end
    endtask

    task automatic test_gaps_cancel();
        for (int k = 0; k < 9; k++) begin
            to_next();
            rv[0] = (k == 0 || k == 6) ? 2'b10 : ((k == 1) ? 2'b11 : 2'b00);
            ra[0] = (k == 1) ? {8'd9, 8'd6} : ((k == 6) ? {8'd12, 8'd0} : {8'd10, 8'd0});
            rb[0] = (k == 1) ? {8'd9, 8'd7} : ((k == 6) ? {8'd13, 8'd0} : {8'd10, 8'd0});
            @(negedge clk);
            model_eval(0);
            checks++;
            if (obs_vec(0) !== exp_vec[0]) begin
                errors++;
                $display("FAIL gaps_model cyc=%0d got=%h exp=%h", cyc, obs_vec(0), exp_vec[0]);
            end
            if (k == 1) begin
                checks++;
                if (o_ready[0] !== 2'b01) begin
                    errors++;
                    $display("FAIL gaps_grant got=%b exp=01", o_ready[0]);
                end
            end
            if (k >= 2 && k <= 5) begin
                checks++;
                if (o_rv[0][1] !== 1'b0) begin
                    errors++;
                    $display("FAIL cancel_rsp k=%0d got=%b exp=0", k, o_rv[0][1]);
                end
            end
            if (k >= 3 && k <= 5) begin
                checks++;
                if (o_en[0] !== 1'b0) begin
                    errors++;
                    $display("FAIL idle_en k=%0d got=%b exp=0", k, o_en[0]);
                end
            end
            if (k == 7) begin
                checks++;
                if ({o_rv[0], o_rd[0]} !== {2'b10, 16'd156}) begin
                    errors++;
                    $display("FAIL isolated_rsp got=%b/%0d exp=10/156", o_rv[0], o_rd[0]);
                end
            end
            model_commit(0);
        end
    endtask

    task automatic test_pipeline();
        logic [7:0]  pa [3];
        logic [15:0] pe [3];
        pa[0] = 8'd255; pa[1] = 8'd1; pa[2] = 8'd16;
        pe[0] = 16'd65025; pe[1] = 16'd1; pe[2] = 16'd256;
        for (int k = 0; k < 8; k++) begin
            to_next();
            rv[1] = (k < 3) ? 2'b10 : 2'b00;
            ra[1] = {pa[k % 3], 8'd0};
            rb[1] = {pa[k % 3], 8'd0};
            @(negedge clk);
            model_eval(1);
            checks++;
            if (obs_vec(1) !== exp_vec[1]) begin
                errors++;
                $display("FAIL pipe_model cyc=%0d got=%h exp=%h", cyc, obs_vec(1), exp_vec[1]);
            end
            if (k <= 6) begin
                checks++;
                if (o_en[1] !== ((k <= 5) ? 1'b1 : 1'b0)) begin
                    errors++;
                    $display("FAIL pipe_en k=%0d got=%b exp=%b", k, o_en[1], (k <= 5) ? 1'b1 : 1'b0);
                end
            end
            if (k >= 3 && k <= 5) begin
                checks++;
                if ({o_rv[1], o_rd[1]} !== {2'b10, pe[k-3]}) begin
                    errors++;
                    $display("FAIL pipe_rsp k=%0d got=%b/%0d exp=10/%0d", k, o_rv[1], o_rd[1], pe[k-3]);
                end
            end
            model_commit(1);
        end
    endtask

    task automatic test_reset_midflight();
        for (int k = 0; k < 12; k++) begin
            to_next();
            rv[1]   = (k < 2) ? 2'b01 : ((k == 7) ? 2'b11 : 2'b00);
            ra[1]   = (k == 0) ? {8'd0, 8'd5} : {8'd3, 8'd7};
            rb[1]   = (k == 0) ? {8'd0, 8'd6} : {8'd4, 8'd8};
            rstn[1] = (k == 2) ? 1'b0 : 1'b1;
            @(negedge clk);
            model_eval(1);
            checks++;
            if (obs_vec(1) !== exp_vec[1]) begin
                errors++;
                $display("FAIL midreset_model cyc=%0d got=%h exp=%h", cyc, obs_vec(1), exp_vec[1]);
            end
            if (k >= 2 && k <= 6) begin
                checks++;
                if (o_rv[1] !== 2'b00) begin
                    errors++;
                    $display("FAIL midreset_rsp k=%0d got=%b exp=00", k, o_rv[1]);
                end
            end
            if (k == 7) begin
                checks++;
                if (o_ready[1] !== 2'b01) begin
                    errors++;
                    $display("FAIL midreset_grant got=%b exp=01", o_ready[1]);
                end
            end
            model_commit(1);
        end
    endtask

    task automatic test_random(input int d);
        int g;
        g = -1;
        for (int n = 0; n < 206; n++) begin
            to_next();
            for (int i = 0; i < 2; i++) begin
                if (n >= 200) begin
                    rv[d][i] = 1'b0;
                end else if (rv[d][i] && g != i) begin
                    if ($urandom_range(7) == 0) rv[d][i] = 1'b0;
                end else begin
                    rv[d][i]         = 1'($urandom_range(1));
                    ra[d][i*8 +: 8]  = 8'($urandom);
                    rb[d][i*8 +: 8]  = 8'($urandom);
                end
            end
            @(negedge clk);
            model_eval(d);
            checks++;
            if (obs_vec(d) !== exp_vec[d]) begin
                errors++;
                $display("FAIL random dut%0d cyc=%0d got=%h exp=%h", d, cyc, obs_vec(d), exp_vec[d]);
            end
            g = exp_gid[d];
            model_commit(d);
        end
    endtask

    initial begin
        rstn  = 2'b00;
        rv[0] = 2'b00; rv[1] = 2'b00;
        ra[0] = 16'd0; ra[1] = 16'd0;
        rb[0] = 16'd0; rb[1] = 16'd0;
        ptr[0] = 1; ptr[1] = 1;
        test_reset();
        test_contention();
        test_single();
        test_gaps_cancel();
        test_pipeline();
        test_reset_midflight();
        test_random(0);
        test_random(1);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
